// File: rtl/fetch_stage.sv
// Instruction fetch stage: boots the PC from a two-word reset vector at
// addresses 0/1, then drives the PC and the IF/ID register with stall,
// flush, redirect and latched-interrupt handling.
module fetch_stage (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        JmpTaken,
  input  logic [31:0] JmpAddr,
  input  logic        Interrupt,
  input  logic [15:0] InPort,
  input  logic        IdExMemRead,
  input  logic [2:0]  IdExRdst,
  output logic [31:0] InstrAddr,
  input  logic [15:0] InstrData,
  output logic [68:0] Out,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    BOOT_LO = 2'd0,
    BOOT_HI = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        int_pend_q, int_pend_d;
  logic [68:0] out_q, out_d;

  logic [31:0] pc_plus1;
  logic        deliver;

  assign pc_plus1 = pc_q + 32'd1;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= BOOT_LO;
      pc_q       <= 32'h0;
      int_pend_q <= 1'b0;
      out_q      <= 69'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      int_pend_q <= int_pend_d;
      out_q      <= out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    out_d     = out_q;
    deliver   = 1'b0;
    InstrAddr = pc_q;
    unique case (state_q)
      BOOT_LO: begin
        InstrAddr = 32'd0;
        pc_d      = {16'h0000, InstrData};
        out_d     = 69'h0;
        state_d   = BOOT_HI;
      end
      BOOT_HI: begin
        InstrAddr = 32'd1;
        pc_d      = {InstrData, pc_q[15:0]};
        out_d     = 69'h0;
        state_d   = RUN;
      end
      RUN: begin
        if (JmpTaken)   pc_d = JmpAddr;
        else if (Stall) pc_d = pc_q;
        else            pc_d = pc_plus1;
        // A redirect squashes the fetched word even when decode is stalling.
        if (Flush || JmpTaken) begin
          out_d = {InPort, pc_plus1, 16'h0000, 1'b0, IdExMemRead, IdExRdst};
        end else if (!Stall) begin
          out_d   = {InPort, pc_plus1, InstrData, int_pend_q, IdExMemRead, IdExRdst};
          deliver = 1'b1;
        end
      end
      default: begin
        state_d = BOOT_LO;
      end
    endcase
  end

  // A new request arriving on a delivery cycle stays pending for the next one.
  assign int_pend_d = Interrupt | (int_pend_q & ~deliver);

  assign Out         = out_q;
  assign dbg_state_o = state_q;

endmodule
